bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 120 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: unsigned binary -> packed BCD, one bit per clock.
// Optional overflow flag enabled by defining BIN2BCD_OVF_EN; otherwise ovf is tied low.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy,
  output logic                  ovf,
  output logic [1:0]            o_dbg_state
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; out_valid/bcd/ovf stay stable until that transfer occurs.
  state_t          r_state;
  logic [WIDTH-1:0] r_bin;
  logic [BW-1:0]   r_bcd;
  logic [CW-1:0]   r_cnt;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Adjusted BCD bits that survive the left shift; the top bit of the
  // top digit falls off and is handled by the overflow logic only.
  logic [BW-2:0] w_adj;

  genvar gd;
  generate
    for (gd = 0; gd < DIGITS - 1; gd++) begin : g_adj
      assign w_adj[4*gd +: 4] = add3(r_bcd[4*gd +: 4]);
    end
  endgenerate
  assign w_adj[BW-2 -: 3] = 3'(add3(r_bcd[BW-1 -: 4]));

  logic w_last;
  assign w_last = (r_cnt == LAST_ITER);

`ifdef BIN2BCD_OVF_EN
  logic r_ovf;
  logic w_carry;
  // A legal digit >= 5 becomes >= 8 after +3, so its MSB is what shifts out.
  assign w_carry = (r_bcd[BW-1 -: 4] >= 4'd5);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
`ifdef BIN2BCD_OVF_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_bin   <= bin;
            r_bcd   <= '0;
            r_cnt   <= '0;
`ifdef BIN2BCD_OVF_EN
            r_ovf   <= 1'b0;
`endif
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bcd <= {w_adj, r_bin[WIDTH-1]};
          r_bin <= r_bin << 1;
          r_cnt <= r_cnt + 1'b1;
`ifdef BIN2BCD_OVF_EN
          r_ovf <= r_ovf | w_carry;
`endif
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign busy        = (r_state == S_SHIFT);
  assign out_valid   = (r_state == S_DONE);
  assign bcd         = r_bcd;
  assign o_dbg_state = r_state;

`ifdef BIN2BCD_OVF_EN
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed vectors, expected-result queues, and
// monitors that compare whenever a result is handed off.
module tb_bin_to_bcd_seq;

  localparam int W  = 8;
  localparam int D  = 3;
  localparam int D2 = 2;
`ifdef BIN2BCD_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (DIGITS=3)
  logic          in_valid, in_ready, out_valid, out_ready, busy, ovf;
  logic [W-1:0]  bin;
  logic [4*D-1:0] bcd;
  logic [1:0]    dbg_state;

  // narrow instance (DIGITS=2) for the overflow case
  logic           in_valid2, in_ready2, out_valid2, out_ready2, busy2, ovf2;
  logic [W-1:0]   bin2;
  logic [4*D2-1:0] bcd2;
  logic [1:0]     dbg_state2;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd),
    .busy(busy), .ovf(ovf), .o_dbg_state(dbg_state)
  );

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D2)) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .bin(bin2),
    .out_valid(out_valid2), .out_ready(out_ready2), .bcd(bcd2),
    .busy(busy2), .ovf(ovf2), .o_dbg_state(dbg_state2)
  );

  // ---------------- scoreboard ----------------
  int n_pass  = 0;
  int n_total = 0;

  // entry = {excess-3 of digit 0, ovf, bcd}
  logic [16:0] exp_q[$];
  // entry = {ovf, bcd}
  logic [8:0]  exp2_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name);
    n_total++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_output");
      end else begin
        logic [16:0] e;
        logic [3:0]  ex3;
        e   = exp_q.pop_front();
        ex3 = bcd[3:0] + 4'd3;
        check("bcd", 32'(bcd), 32'(e[11:0]));
        check("ovf", 32'(ovf), 32'(e[12]));
        check("ex3_d0", 32'(ex3), 32'(e[16:13]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid2 && out_ready2) begin
      if (exp2_q.size() == 0) begin
        fail("unexpected_output2");
      end else begin
        logic [8:0] e;
        e = exp2_q.pop_front();
        check("bcd2", 32'(bcd2), 32'(e[7:0]));
        check("ovf2", 32'(ovf2), 32'(e[8]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [W-1:0] v, input logic push,
                      input logic [11:0] e_bcd, input logic [3:0] e_ex3);
    int t = 0;
    while (!in_ready && t < 40) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 40) fail("in_ready_timeout");
    in_valid = 1'b1;
    bin      = v;
    if (push) exp_q.push_back({e_ex3, 1'b0, e_bcd});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) fail("done_timeout");
    @(posedge clk); #1;
  endtask

  task automatic send2(input logic [W-1:0] v, input logic e_ovf, input logic [7:0] e_bcd);
    int n = 0;
    while (!in_ready2 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    in_valid2 = 1'b1;
    bin2      = v;
    exp2_q.push_back({e_ovf, e_bcd});
    @(posedge clk); #1;
    in_valid2 = 1'b0;
    n = 0;
    while (!out_valid2 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 40) fail("done2_timeout");
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int lat;
    int seen;
    rst        = 1'b1;
    in_valid   = 1'b0;
    bin        = '0;
    out_ready  = 1'b0;
    in_valid2  = 1'b0;
    bin2       = '0;
    out_ready2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // max value and latency
    out_ready = 1'b1;
    send(8'd255, 1'b1, 12'h255, 4'h8);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("state_shift", 32'(dbg_state), 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    check("latency_255", 32'(lat), 32'd8);
    check("state_done", 32'(dbg_state), 32'd2);
    @(posedge clk); #1;
    check("idle_after_hs", 32'(in_ready), 32'd1);

    // zero and nine
    send(8'd0, 1'b1, 12'h000, 4'h3);
    wait_done(lat);
    send(8'd9, 1'b1, 12'h009, 4'hC);
    wait_done(lat);

    // back-pressure
    out_ready = 1'b0;
    send(8'd128, 1'b1, 12'h128, 4'hB);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    for (int i = 0; i < 5; i++) begin
      check("bp_bcd", 32'(bcd), 32'h128);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);

    // input while busy is ignored
    send(8'd42, 1'b1, 12'h042, 4'h5);
    @(posedge clk); #1;
    check("busy_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    bin      = 8'd77;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(lat);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("no_extra_output", 32'(seen), 32'd0);

    // reset in the middle of SHIFT; operand must never be emitted
    send(8'd200, 1'b0, 12'h000, 4'h0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    bin      = 8'd55;
    @(posedge clk); #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_bcd", 32'(bcd), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("midrst_no_output", 32'(seen), 32'd0);
    send(8'd99, 1'b1, 12'h099, 4'hC);
    wait_done(lat);

    // overflow on the two-digit instance
    send2(8'd200, OVF_ON, 8'h00);
    send2(8'd99, 1'b0, 8'h99);
    send2(8'd100, OVF_ON, 8'h00);

    repeat (3) @(posedge clk);
    #1;
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("exp2_q_drained", 32'(exp2_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1);
  end

endmodule
